// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the serial instruction-memory loader.
package imem_loader_pkg;

   // Loader FSM states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CNT_LO = 3'd1,
      ST_CNT_HI = 3'd2,
      ST_DATA   = 3'd3,
      ST_CHECK  = 3'd4,
      ST_DONE   = 3'd5,
      ST_ERR    = 3'd6
   } state_e;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

   // Frame field order: sync, count low, count high, payload..., checksum
   localparam int FLD_SYNC       = 0;
   localparam int FLD_CNT_LO     = 1;
   localparam int FLD_CNT_HI     = 2;
   localparam int FLD_PAYLOAD    = 3;
   localparam int BYTES_PER_WORD = 4;

   // True while a frame is being received (timeout applies here)
   function automatic logic in_frame(input state_e s);
      return (s == ST_CNT_LO) || (s == ST_CNT_HI) || (s == ST_DATA) || (s == ST_CHECK);
   endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Packs payload bytes little-endian into 32-bit words; pulses word_ready
// the cycle after the fourth byte while word still holds the full value.
module imem_word_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        byte_vld,
   input  logic [7:0]  byte_data,
   output logic        last_byte,
   output logic        word_ready,
   output logic [31:0] word
);

   logic [1:0]  idx_q, idx_d;
   logic [31:0] asm_q, asm_d;
   logic        rdy_q, rdy_d;

   // Fourth byte of a word is being accepted this cycle
   assign last_byte  = byte_vld && (idx_q == 2'(BYTES_PER_WORD - 1));
   assign word_ready = rdy_q;
   assign word       = asm_q;

   // Byte steering: byte k lands in bits [8k+7:8k]. A first byte of the
   // next word overwrites asm only at the end of the word_ready cycle.
   always_comb begin
      idx_d = idx_q;
      asm_d = asm_q;
      rdy_d = 1'b0;
      if (clr) begin
         idx_d = 2'd0;
      end else if (byte_vld) begin
         asm_d[{idx_q, 3'b000} +: 8] = byte_data;
         idx_d = idx_q + 2'd1;
         rdy_d = last_byte;
      end
   end

   // Packer state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q <= 2'd0;
         asm_q <= 32'd0;
         rdy_q <= 1'b0;
      end else begin
         idx_q <= idx_d;
         asm_q <= asm_d;
         rdy_q <= rdy_d;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Frame receiver that writes a UART-delivered program image into the
// instruction memory and holds the core in reset while loading.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int         DEPTH     = 256,
   parameter int         ADDR_W    = 8,
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
   parameter int         TIMEOUT   = 100000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_waddr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_error,
   output logic [ADDR_W:0]   words_loaded
);

   localparam int TMO_W = $clog2(TIMEOUT + 1);

   state_e              state_q, state_d;
   logic [15:0]         cnt_q, cnt_d;
   logic [ADDR_W:0]     wcnt_q, wcnt_d;
   logic [7:0]          sum_q, sum_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
   logic [ADDR_W-1:0]   waddr_q, waddr_d;
   logic                hold_q, hold_d;
   logic                done_q, done_d;
   logic                err_q, err_d;

   logic                frame_start;
   logic                tmo_hit;
   logic                last_byte;
   logic                word_ready;
   logic [31:0]         word;
   logic [15:0]         n_full;
   logic                last_word;

   assign frame_start = rx_valid && (rx_data == SYNC_BYTE) &&
                        ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));
   assign tmo_hit     = in_frame(state_q) && !rx_valid && (tmo_q == TMO_W'(TIMEOUT - 1));
   assign n_full      = {rx_data, cnt_q[7:0]};
   // The word whose 4th byte is arriving is the last one of the frame.
   // Earlier words have already bumped wcnt since word_ready trails by one cycle.
   assign last_word   = (17'(wcnt_q) + 17'd1) == {1'b0, cnt_q};

   imem_word_packer u_packer (
      .clk        (clk),
      .rst        (reset),
      .clr        (frame_start),
      .byte_vld   (rx_valid && (state_q == ST_DATA)),
      .byte_data  (rx_data),
      .last_byte  (last_byte),
      .word_ready (word_ready),
      .word       (word)
   );

   // State and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         wcnt_q  <= '0;
         sum_q   <= '0;
         tmo_q   <= '0;
         waddr_q <= '0;
         hold_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wcnt_q  <= wcnt_d;
         sum_q   <= sum_d;
         tmo_q   <= tmo_d;
         waddr_q <= waddr_d;
         hold_q  <= hold_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic; the last word's write pulse trails into CHECK so a
   // checksum byte on the very next cycle is not mistaken for payload.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: if (frame_start) state_d = ST_CNT_LO;
         ST_CNT_LO: if (rx_valid) state_d = ST_CNT_HI;
         ST_CNT_HI: if (rx_valid) begin
            if ({1'b0, n_full} > 17'(DEPTH)) state_d = ST_ERR;
            else if (n_full == 16'd0)        state_d = ST_CHECK;
            else                             state_d = ST_DATA;
         end
         ST_DATA:  if (last_byte && last_word) state_d = ST_CHECK;
         ST_CHECK: if (rx_valid) state_d = (rx_data == sum_q) ? ST_DONE : ST_ERR;
         default:  state_d = ST_IDLE;
      endcase
      if (tmo_hit) state_d = ST_ERR;
   end

   // Counters, checksum, address capture and status flags
   always_comb begin
      cnt_d   = cnt_q;
      wcnt_d  = wcnt_q;
      sum_d   = sum_q;
      waddr_d = waddr_q;
      tmo_d   = (in_frame(state_q) && !rx_valid) ? tmo_q + TMO_W'(1) : '0;
      if (frame_start) begin
         cnt_d  = '0;
         wcnt_d = '0;
         sum_d  = '0;
      end else begin
         if (word_ready) wcnt_d = wcnt_q + 1'b1;
         if (rx_valid && (state_q == ST_CNT_LO)) cnt_d[7:0]  = rx_data;
         if (rx_valid && (state_q == ST_CNT_HI)) cnt_d[15:8] = rx_data;
         if (rx_valid && (state_q == ST_DATA))   sum_d       = sum_q + rx_data;
      end
      if (last_byte) waddr_d = wcnt_q[ADDR_W-1:0];
      hold_d = in_frame(state_d) || (state_d == ST_ERR);
      done_d = (state_d == ST_DONE);
      err_d  = (state_d == ST_ERR);
   end

   assign imem_we      = word_ready;
   assign imem_waddr   = waddr_q;
   assign imem_wdata   = word;
   assign cpu_hold     = hold_q;
   assign load_done    = done_q;
   assign load_error   = err_q;
   assign words_loaded = wcnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framed loads, checksum error, count
// overflow, timeout, reset mid-frame and an empty frame.
module tb_imem_loader;

   localparam int TMO = 20;

   typedef logic [7:0] bytes_t [$];

   logic        clk;
   logic        reset;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        imem_we;
   logic [7:0]  imem_waddr;
   logic [31:0] imem_wdata;
   logic        cpu_hold;
   logic        load_done;
   logic        load_error;
   logic [8:0]  words_loaded;

   int          n_chk;
   int          n_fail;
   int          nw;
   logic [7:0]  wa [0:63];
   logic [31:0] wd [0:63];
   int          base;
   bytes_t      frm;

   imem_loader #(.DEPTH(256), .ADDR_W(8), .SYNC_BYTE(8'hA5), .TIMEOUT(TMO)) dut (
      .clk          (clk),
      .reset        (reset),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .imem_we      (imem_we),
      .imem_waddr   (imem_waddr),
      .imem_wdata   (imem_wdata),
      .cpu_hold     (cpu_hold),
      .load_done    (load_done),
      .load_error   (load_error),
      .words_loaded (words_loaded)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // write-port log, sampled on the falling edge
   initial nw = 0;
   always @(negedge clk) begin
      if (imem_we === 1'b1 && nw < 64) begin
         wa[nw] = imem_waddr;
         wd[nw] = imem_wdata;
         nw = nw + 1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_frame(input bytes_t f);
      foreach (f[i]) send(f[i]);
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic chk_status(input string tag, input logic h, input logic d, input logic e);
      chk({tag, "_hold"}, 64'(cpu_hold), 64'(h));
      chk({tag, "_done"}, 64'(load_done), 64'(d));
      chk({tag, "_err"},  64'(load_error), 64'(e));
   endtask

   initial begin
      n_chk = 0; n_fail = 0;
      reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_we",    64'(imem_we), 64'd0);
      chk("rst_waddr", 64'(imem_waddr), 64'd0);
      chk("rst_wdata", 64'(imem_wdata), 64'd0);
      chk("rst_words", 64'(words_loaded), 64'd0);
      chk_status("rst", 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      idle(1);

      // good 2-word load
      base = nw;
      frm = '{8'hA5, 8'h02, 8'h00};
      send_frame(frm);
      chk("good_hold_mid", 64'(cpu_hold), 64'd1);
      frm = '{8'h13, 8'h03, 8'h00, 8'h08, 8'h83, 8'h23, 8'h03, 8'h00, 8'hC7};
      send_frame(frm);
      idle(2);
      chk("good_nw",    64'(nw - base), 64'd2);
      chk("good_a0",    64'(wa[base]), 64'd0);
      chk("good_d0",    64'(wd[base]), 64'h08000313);
      chk("good_a1",    64'(wa[base+1]), 64'd1);
      chk("good_d1",    64'(wd[base+1]), 64'h00032383);
      chk("good_words", 64'(words_loaded), 64'd2);
      chk_status("good", 1'b0, 1'b1, 1'b0);

      // same frame, wrong checksum
      base = nw;
      frm = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h03, 8'h00, 8'h08, 8'h83, 8'h23, 8'h03, 8'h00, 8'hC6};
      send_frame(frm);
      idle(2);
      chk("badchk_nw", 64'(nw - base), 64'd2);
      chk("badchk_a1", 64'(wa[base+1]), 64'd1);
      chk_status("badchk", 1'b1, 1'b0, 1'b1);

      // count overflow N=257
      base = nw;
      frm = '{8'hA5, 8'h01, 8'h01};
      send_frame(frm);
      idle(3);
      chk("ovf_nw", 64'(nw - base), 64'd0);
      chk_status("ovf", 1'b1, 1'b0, 1'b1);
      frm = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h03, 8'h00, 8'h08, 8'h83, 8'h23, 8'h03, 8'h00, 8'hC7};
      send_frame(frm);
      idle(2);
      chk("ovf_rec_nw", 64'(nw - base), 64'd2);
      chk_status("ovf_rec", 1'b0, 1'b1, 1'b0);

      // timeout inside DATA, exact boundary
      base = nw;
      frm = '{8'hA5, 8'h01, 8'h00, 8'h13, 8'h03};
      send_frame(frm);
      idle(TMO - 1);
      chk("tmo_pre_err", 64'(load_error), 64'd0);
      idle(1);
      chk_status("tmo", 1'b1, 1'b0, 1'b1);
      send(8'h13);
      send(8'h00);
      idle(2);
      chk("tmo_nw", 64'(nw - base), 64'd0);
      chk_status("tmo_ign", 1'b1, 1'b0, 1'b1);
      chk("tmo_words", 64'(words_loaded), 64'd0);

      // reset mid-DATA after 1 of 3 words
      base = nw;
      frm = '{8'hA5, 8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      send_frame(frm);
      idle(2);
      chk("mid_nw",    64'(nw - base), 64'd1);
      chk("mid_words", 64'(words_loaded), 64'd1);
      #2 reset = 1'b1;
      #1;
      chk("mrst_we",    64'(imem_we), 64'd0);
      chk("mrst_waddr", 64'(imem_waddr), 64'd0);
      chk("mrst_wdata", 64'(imem_wdata), 64'd0);
      chk("mrst_words", 64'(words_loaded), 64'd0);
      chk_status("mrst", 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      reset = 1'b0;
      base = nw;
      frm = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
      send_frame(frm);
      idle(2);
      chk("one_nw", 64'(nw - base), 64'd1);
      chk("one_a0", 64'(wa[base]), 64'd0);
      chk("one_d0", 64'(wd[base]), 64'h44332211);
      chk_status("one", 1'b0, 1'b1, 1'b0);

      // empty frame N=0
      base = nw;
      frm = '{8'hA5, 8'h00, 8'h00, 8'h00};
      send_frame(frm);
      idle(2);
      chk("n0_nw",    64'(nw - base), 64'd0);
      chk("n0_words", 64'(words_loaded), 64'd0);
      chk_status("n0", 1'b0, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
